// File: rtl/pwm_capture.sv
// PWM input-capture peripheral: measures period and high time of an asynchronous PWM
// input in clk cycles, and reports stuck-high / stuck-low inputs as a sticky timeout.
module pwm_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  logic        pwm_in,
  input  logic [15:0] timeout,
  output logic [15:0] period_out,
  output logic [15:0] high_out,
  output logic        meas_valid,
  output logic        meas_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] high_lat_q, high_lat_d;
  logic [15:0] period_q, period_d;
  logic [15:0] high_q, high_d;
  logic        valid_q, valid_d;
  logic        tmo_q, tmo_d;
  logic        s1_q, s2_q, s2d_q;

  logic        rise, fall, edge_seen, tmo_hit;
  logic [15:0] cnt_inc;

  assign rise      = s2_q & ~s2d_q;
  assign fall      = ~s2_q & s2d_q;
  assign edge_seen = rise | fall;
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign tmo_hit   = ((timeout != 16'd0) && (cnt_q >= timeout)) || (cnt_q == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s2d_q      <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      high_lat_q <= 16'd0;
      period_q   <= 16'd0;
      high_q     <= 16'd0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      s1_q       <= pwm_in;
      s2_q       <= s1_q;
      s2d_q      <= s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    tmo_d      = tmo_q;

    if (!cap_en) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = 16'd0;
        end
        // The period in progress at enable is unknown, so wait for a clean rising edge.
        ARM: begin
          cnt_d = cnt_inc;
          if (rise) begin
            cnt_d   = 16'd1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          cnt_d = cnt_inc;
          if (fall) begin
            high_lat_d = cnt_q;
            state_d    = LOW;
          end
        end
        LOW: begin
          cnt_d = cnt_inc;
          if (rise) begin
            period_d = cnt_q;
            high_d   = high_lat_q;
            valid_d  = 1'b1;
            tmo_d    = 1'b0;
            cnt_d    = 16'd1;
            state_d  = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase

      // Any edge this cycle suppresses the timeout so a legitimate edge always wins.
      if ((state_q != IDLE) && !edge_seen && tmo_hit) begin
        period_d = 16'd0;
        high_d   = s2_q ? 16'hFFFF : 16'd0;
        valid_d  = 1'b1;
        tmo_d    = 1'b1;
        cnt_d    = 16'd0;
        state_d  = ARM;
      end
    end
  end

  assign period_out   = period_q;
  assign high_out     = high_q;
  assign meas_valid   = valid_q;
  assign meas_timeout = tmo_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised self-checking bench for pwm_capture against a timestamp-based reference model.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_en;
  logic        pwm_in;
  logic [15:0] timeout;
  logic [15:0] period_out;
  logic [15:0] high_out;
  logic        meas_valid;
  logic        meas_timeout;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit full_cmp = 1'b1;
  int vcount   = 0;

  // Reference model: measurement time is kept as an origin timestamp, count = now - origin.
  bit          ms1, ms2, ms2d;
  bit          m_on, m_meas, m_fell;
  bit          e_val, e_to;
  logic [15:0] e_per, e_high, m_hl;
  longint      t   = 0;
  longint      org = 0;

  pwm_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .pwm_in      (pwm_in),
    .timeout     (timeout),
    .period_out  (period_out),
    .high_out    (high_out),
    .meas_valid  (meas_valid),
    .meas_timeout(meas_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    ms1 = 1'b0; ms2 = 1'b0; ms2d = 1'b0;
    m_on = 1'b0; m_meas = 1'b0; m_fell = 1'b0;
    e_val = 1'b0; e_to = 1'b0;
    e_per = 16'd0; e_high = 16'd0; m_hl = 16'd0;
  endtask

  task automatic model_timeout();
    e_per  = 16'd0;
    e_high = ms2 ? 16'hFFFF : 16'd0;
    e_val  = 1'b1;
    e_to   = 1'b1;
    m_meas = 1'b0;
    org    = t + 1;
  endtask

  task automatic model_step();
    bit          rise, fall, any_edge, hit;
    longint      d;
    logic [15:0] c;
    rise     = ms2 & ~ms2d;
    fall     = ~ms2 & ms2d;
    any_edge = rise | fall;
    d        = t - org;
    c        = (d >= 65535) ? 16'hFFFF : 16'(d);
    hit      = ((timeout != 16'd0) && (c >= timeout)) || (c == 16'hFFFF);
    e_val    = 1'b0;
    if (!cap_en) begin
      m_on = 1'b0;
      e_to = 1'b0;
    end else if (!m_on) begin
      m_on   = 1'b1;
      m_meas = 1'b0;
      org    = t + 1;
    end else if (!m_meas) begin
      if (rise) begin
        m_meas = 1'b1;
        m_fell = 1'b0;
        org    = t;
      end else if (!any_edge && hit) model_timeout();
    end else if (!m_fell) begin
      if (fall) begin
        m_hl   = c;
        m_fell = 1'b1;
      end else if (!any_edge && hit) model_timeout();
    end else begin
      if (rise) begin
        e_per  = c;
        e_high = m_hl;
        e_val  = 1'b1;
        e_to   = 1'b0;
        m_fell = 1'b0;
        org    = t;
      end else if (!any_edge && hit) model_timeout();
    end
    ms2d = ms2;
    ms2  = ms1;
    ms1  = pwm_in;
    t++;
  endtask

  task automatic tick(input bit p, input bit en);
    @(negedge clk);
    pwm_in = p;
    cap_en = en;
    @(posedge clk);
    model_step();
    #1;
    if (meas_valid) vcount++;
    if (full_cmp || meas_valid || e_val) begin
      check("valid",  32'(meas_valid),   32'(e_val));
      check("period", 32'(period_out),   32'(e_per));
      check("high",   32'(high_out),     32'(e_high));
      check("tmo",    32'(meas_timeout), 32'(e_to));
      check("busy",   32'(busy),         32'(m_on));
    end
  endtask

  task automatic hold(input bit p, input int n, input bit en);
    for (int i = 0; i < n; i++) tick(p, en);
  endtask

  task automatic wave(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      hold(1'b1, h, 1'b1);
      hold(1'b0, l, 1'b1);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cap_en  = 1'b0;
    pwm_in  = 1'b0;
    timeout = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_period", 32'(period_out),   32'd0);
    check("rst_high",   32'(high_out),     32'd0);
    check("rst_valid",  32'(meas_valid),   32'd0);
    check("rst_tmo",    32'(meas_timeout), 32'd0);
    check("rst_busy",   32'(busy),         32'd0);
    rst_n = 1'b1;

    wave(3, 7, 8);
    check("p10_period", 32'(period_out),   32'd10);
    check("p10_high",   32'(high_out),     32'd3);
    check("p10_tmo",    32'(meas_timeout), 32'd0);

    wave(5, 3, 5);
    check("p8_period", 32'(period_out), 32'd8);
    check("p8_high",   32'(high_out),   32'd5);
    wave(1, 19, 4);
    check("h1_high", 32'(high_out), 32'd1);
    wave(19, 1, 4);
    check("h19_high", 32'(high_out), 32'd19);

    timeout = 16'd50;
    hold(1'b0, 2, 1'b0);
    hold(1'b0, 160, 1'b1);
    check("low_tmo",    32'(meas_timeout), 32'd1);
    check("low_period", 32'(period_out),   32'd0);
    check("low_high",   32'(high_out),     32'd0);
    wave(3, 7, 4);
    check("tmo_clear", 32'(meas_timeout), 32'd0);

    timeout = 16'd100;
    hold(1'b1, 150, 1'b1);
    check("stuck_hi_high", 32'(high_out),     32'hFFFF);
    check("stuck_hi_per",  32'(period_out),   32'd0);
    check("stuck_hi_tmo",  32'(meas_timeout), 32'd1);

    timeout = 16'd0;
    hold(1'b0, 3, 1'b1);
    full_cmp = 1'b0;
    vcount   = 0;
    hold(1'b1, 65545, 1'b1);
    full_cmp = 1'b1;
    check("sat_reports", 32'(vcount),   32'd1);
    check("sat_high",    32'(high_out), 32'hFFFF);

    wave(3, 7, 3);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check("dis_busy",   32'(busy),       32'd0);
    check("dis_valid",  32'(meas_valid), 32'd0);
    check("dis_period", 32'(period_out), 32'd10);
    check("dis_high",   32'(high_out),   32'd3);
    hold(1'b0, 3, 1'b0);
    wave(3, 7, 3);

    wave(3, 7, 2);
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 4, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_period", 32'(period_out),   32'd0);
    check("arst_high",   32'(high_out),     32'd0);
    check("arst_valid",  32'(meas_valid),   32'd0);
    check("arst_tmo",    32'(meas_timeout), 32'd0);
    check("arst_busy",   32'(busy),         32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    timeout = 16'd10;
    wave(3, 7, 5);
    check("edge_wins_tmo",    32'(meas_timeout), 32'd0);
    check("edge_wins_period", 32'(period_out),   32'd10);

    for (int seg = 0; seg < 40; seg++) begin
      int kind;
      kind = int'($urandom_range(9, 0));
      if (kind == 0) timeout = 16'($urandom_range(40, 0));
      if (kind < 6)
        wave(int'($urandom_range(25, 1)), int'($urandom_range(25, 1)), int'($urandom_range(4, 1)));
      else if (kind < 8)
        hold(1'($urandom_range(1, 0)), int'($urandom_range(60, 1)), 1'b1);
      else
        hold(1'($urandom_range(1, 0)), int'($urandom_range(3, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
